tile_axi_loader: RTL and testbench
==================================

Name: tile_axi_loader

Overview:
- AXI4 read master that fetches one A, one B and one C operand tile from memory for a single tensor-core operation.
- Streams each 256-bit read beat, tagged with matrix id, data type, shape code and beat index, into the downstream AXI-to-SRAM/systolic transform stage.
- The transform stage has no backpressure, so this block owns all sequencing.
- Performs one start-to-done job per command, in the fixed order A, then B, then C.

Parameters:
- ADDR_W, 32, AXI address width.
- ID_W, 4, AXI ID width.
- AXI_ID, 0, constant ARID used on every request.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job request
- base_a  in  ADDR_W  A tile byte address
- base_b  in  ADDR_W  B tile byte address
- base_c  in  ADDR_W  C tile byte address
- type_in  in  params::type_t  operand data type
- rc_in  in  params::rc_t  shape code (00 M32N8, 01 M16N16, 10 M8N32)
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error for last job; cleared on accepted start
- araddr  out  ADDR_W  AXI read address
- arlen  out  8  AXI burst length minus 1
- arsize  out  3  constant 3'b101 (32 B)
- arburst  out  2  constant 2'b01 (INCR)
- arid  out  ID_W  constant AXI_ID
- arvalid  out  1  AXI read address valid
- arready  in  1  AXI read address ready
- rdata  in  256  AXI read data
- rresp  in  2  AXI read response
- rlast  in  1  AXI last beat
- rvalid  in  1  AXI read data valid
- rready  out  1  AXI read data ready
- data_in  out  256  beat to transform stage
- burst_num  out  5  beat index within the current tile
- data_type  out  params::type_t  latched type_in
- mat  out  params::mat_t  current matrix
- rc  out  params::rc_t  latched rc_in
- valid  out  1  data_in qualifier

Behaviour:
- Reset: every output 0, except the constants arsize, arburst and arid. FSM goes to IDLE. All latches cleared.
- FSM states: IDLE, AR, R, DONE. A matrix register holds A, B or C.
- IDLE + start: latch the bases, with address bits [4:0] forced to 0. Latch type and rc. Clear err, set mat=A, set busy=1, go to AR. start is ignored while busy.
- Beats per tile (arlen = beats-1):
  - A: 16 beats for FP32, 8 for all other types.
  - B: 8 beats for FP32, 16 for all other types.
  - C: 32 beats for every type and rc.
- AR state:
  - arvalid=1; araddr is the base of the current matrix.
  - araddr, arlen and arvalid are stable until arready.
  - On arvalid&&arready, go to R and clear the beat counter.
- R state:
  - rready=1 for the whole state; there is no stall.
  - On rvalid, the next cycle has valid=1, data_in=rdata and burst_num=beat counter, with mat/data_type/rc current. Latency is 1 cycle, registered.
  - The counter increments on each rvalid beat.
- Tile end: the beat where the counter equals arlen.
  - rlast must be 1 on that beat. If rlast is 0 there, or 1 on any earlier beat, set err.
  - Termination is by counter only; rlast is never used to terminate.
  - On tile end, advance A to B (AR) or B to C (AR), or C to DONE.
- rresp != 2'b00 on any beat sets err. The job continues and all beats are still forwarded.
- DONE: done=1 for one cycle, busy=0, return to IDLE. A start in the DONE cycle is ignored.
- valid is 0 in every cycle without a forwarded beat. burst_num and data_in hold their last values.
- Only one AR is outstanding at a time, with no address/data overlap.
- Max tile is 1 KiB. Keeping tiles inside one 4 KiB page is the caller's duty; it is not checked.
- Reset mid-job: immediate abort to IDLE, with outputs per the reset rule. No further AXI handshake is owed.

Decomposition:
- type_t, mat_t and rc_t come from the shared params package.
- Add to params: AXI_BEAT_BYTES=32, AXI_SIZE_256=3'b101, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00.
- Add to params: a function beats_for(mat_t, type_t) that returns the burst length.
- No sub-module. The FSM, address mux and beat counter stay in one module.

Test Plan:
- FP32 job, base_a=0x1000, base_b=0x2000, base_c=0x3000, rc=00, arready immediate:
  - ARs are (0x1000, arlen 15), (0x2000, 7), (0x3000, 31) in that order.
  - 56 valid beats with burst_num 0..15, 0..7, 0..31, each one cycle after its rvalid.
  - done once, err=0.
- INT8 job, rc=01, random arready/rvalid gaps:
  - arlen is 7/15/31.
  - araddr/arlen held stable while arvalid&&!arready.
  - Forwarded data matches rdata in order.
- base_a=0x101F:
  - araddr=0x1000 (low bits forced to 0).
- rresp=2'b10 on A beat 3:
  - err=1 at done.
  - All 8/16/32 beats still forwarded.
  - Next start clears err.
- rlast asserted on beat 5 of a 16-beat tile:
  - err=1.
  - The tile still ends after the counter reaches 15.
- start while busy is ignored.
- rst_n low during B's R phase:
  - busy=0, arvalid=0, valid=0 immediately.
  - After reset release, a new start runs a clean A/B/C sequence.

Source files
------------

// File: rtl/params.sv
// Shared tensor-core operand types and AXI constants used by the tile loader.
package params;

  typedef enum logic [1:0] {
    TypeInt8 = 2'd0,
    TypeFp16 = 2'd1,
    TypeBf16 = 2'd2,
    TypeFp32 = 2'd3
  } type_t;

  typedef enum logic [1:0] {
    MatA = 2'd0,
    MatB = 2'd1,
    MatC = 2'd2
  } mat_t;

  typedef enum logic [1:0] {
    RcM32N8  = 2'd0,
    RcM16N16 = 2'd1,
    RcM8N32  = 2'd2
  } rc_t;

  localparam int unsigned AXI_BEAT_BYTES = 32;
  localparam logic [2:0]  AXI_SIZE_256   = 3'b101;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

  // Number of 256-bit beats in one operand tile; arlen is this minus one.
  function automatic logic [5:0] beats_for(input mat_t m, input type_t t);
    logic [5:0] beats;
    case (m)
      MatA:    beats = (t == TypeFp32) ? 6'd16 : 6'd8;
      MatB:    beats = (t == TypeFp32) ? 6'd8 : 6'd16;
      default: beats = 6'd32;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/tile_axi_loader.sv
// AXI4 read master that fetches the A, B and C tiles of one tensor-core op and
// forwards every read beat, tagged, to the transform stage one cycle later.
module tile_axi_loader
  import params::*;
#(
  parameter int unsigned     ADDR_W = 32,
  parameter int unsigned     ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  type_t             type_in,
  input  rc_t               rc_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [ID_W-1:0]   arid,
  output logic              arvalid,
  input  logic              arready,
  input  logic [255:0]      rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [255:0]      data_in,
  output logic [4:0]        burst_num,
  output type_t             data_type,
  output mat_t              mat,
  output rc_t               rc,
  output logic              valid
);

  localparam logic [ADDR_W-1:0] AlignMask = ~(ADDR_W'(AXI_BEAT_BYTES - 1));

  typedef enum logic [1:0] {StIdle, StAr, StR, StDone} state_e;

  state_e            state_q, state_d;
  mat_t              cur_q, cur_d;
  mat_t              tag_q, tag_d;
  logic [ADDR_W-1:0] base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
  type_t             type_q, type_d;
  rc_t               rc_q, rc_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [4:0]        bnum_q, bnum_d;
  logic [255:0]      data_q, data_d;
  logic [7:0]        len;
  logic              last_beat;

  assign len       = {2'b00, beats_for(cur_q, type_q)} - 8'd1;
  assign last_beat = ({3'b000, cnt_q} == len);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    tag_d    = tag_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    base_c_d = base_c_q;
    type_d   = type_q;
    rc_d     = rc_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    cnt_d    = cnt_q;
    bnum_d   = bnum_q;
    data_d   = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_a_d = base_a & AlignMask;
          base_b_d = base_b & AlignMask;
          base_c_d = base_c & AlignMask;
          type_d   = type_in;
          rc_d     = rc_in;
          err_d    = 1'b0;
          cur_d    = MatA;
          tag_d    = MatA;
          state_d  = StAr;
        end
      end
      StAr: begin
        if (arready) begin
          cnt_d   = '0;
          state_d = StR;
        end
      end
      StR: begin
        if (rvalid) begin
          valid_d = 1'b1;
          data_d  = rdata;
          bnum_d  = cnt_q;
          tag_d   = cur_q;
          cnt_d   = cnt_q + 5'd1;
          if (rresp != AXI_RESP_OKAY) err_d = 1'b1;
          // rlast only flags protocol errors; the beat counter ends the tile.
          if (rlast != last_beat) err_d = 1'b1;
          if (last_beat) begin
            case (cur_q)
              MatA: begin
                cur_d   = MatB;
                state_d = StAr;
              end
              MatB: begin
                cur_d   = MatC;
                state_d = StAr;
              end
              default: state_d = StDone;
            endcase
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cur_q    <= MatA;
      tag_q    <= MatA;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      type_q   <= TypeInt8;
      rc_q     <= RcM32N8;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      bnum_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      tag_q    <= tag_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_c_q <= base_c_d;
      type_q   <= type_d;
      rc_q     <= rc_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      bnum_q   <= bnum_d;
      data_q   <= data_d;
    end
  end

  assign busy    = (state_q == StAr) || (state_q == StR);
  assign done    = (state_q == StDone);
  assign arvalid = (state_q == StAr);
  assign rready  = (state_q == StR);
  assign arlen   = arvalid ? len : 8'd0;
  assign arsize  = AXI_SIZE_256;
  assign arburst = AXI_BURST_INCR;
  assign arid    = AXI_ID;

  always_comb begin
    araddr = '0;
    if (arvalid) begin
      case (cur_q)
        MatA:    araddr = base_a_q;
        MatB:    araddr = base_b_q;
        default: araddr = base_c_q;
      endcase
    end
  end

  assign err       = err_q;
  assign valid     = valid_q;
  assign data_in   = data_q;
  assign burst_num = bnum_q;
  assign data_type = type_q;
  assign rc        = rc_q;
  // Tag follows the forwarded beat, so a tile's last beat keeps its own matrix id.
  assign mat       = tag_q;

endmodule

// File: tb/tb_tile_axi_loader.sv
// Self-checking bench for tile_axi_loader: job table, randomized jobs, reset abort.
module tb_tile_axi_loader;
  import params::*;

  localparam int unsigned     ADDR_W = 32;
  localparam int unsigned     ID_W   = 4;
  localparam logic [ID_W-1:0] TB_ID  = 4'h5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_a, base_b, base_c;
  type_t             type_in;
  rc_t               rc_in;
  logic              busy, done, err;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [ID_W-1:0]   arid;
  logic              arvalid, arready;
  logic [255:0]      rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;
  logic [255:0]      data_in;
  logic [4:0]        burst_num;
  type_t             data_type;
  mat_t              mat;
  rc_t               rc;
  logic              valid;

  tile_axi_loader #(.ADDR_W(ADDR_W), .ID_W(ID_W), .AXI_ID(TB_ID)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .type_in(type_in), .rc_in(rc_in),
    .busy(busy), .done(done), .err(err),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .data_in(data_in), .burst_num(burst_num), .data_type(data_type),
    .mat(mat), .rc(rc), .valid(valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Tile size straight from the beat table: m 0=A, 1=B, 2=C.
  function automatic int beats_ref(input int m, input type_t t);
    if (m == 2) return 32;
    if (m == 0) return (t == TypeFp32) ? 16 : 8;
    return (t == TypeFp32) ? 8 : 16;
  endfunction

  typedef struct {
    logic [31:0] ba, bb, bc;
    type_t       ty;
    rc_t         rcv;
    bit          gaps;
    int          resp_mat, resp_beat;  // bad rresp injection, -1 = none
    int          last_mat, last_beat;  // inverted rlast injection, -1 = none
    bit          exp_err;
  } job_t;

  task automatic run_job(input job_t j, input bit abort_b);
    logic [31:0]  exp_addr [3];
    int           exp_len [3];
    logic [255:0] q_data [$];
    int           q_idx [$];
    int           q_mat [$];
    int           total, ar_seen, fwd, cyc, pm, rem, bidx, ei, em;
    bit           pend, pend_before, exp_v, exp_v_nxt, hold, finished;
    logic [31:0]  h_addr;
    logic [7:0]   h_len;
    logic [255:0] d;
    total = 0; ar_seen = 0; fwd = 0; cyc = 0; pm = 0; rem = 0; bidx = 0;
    pend = 0; exp_v = 0; hold = 0; finished = 0;
    h_addr = '0; h_len = '0;
    exp_addr[0] = j.ba & 32'hffff_ffe0;
    exp_addr[1] = j.bb & 32'hffff_ffe0;
    exp_addr[2] = j.bc & 32'hffff_ffe0;
    for (int m = 0; m < 3; m++) begin
      exp_len[m] = beats_ref(m, j.ty) - 1;
      total += beats_ref(m, j.ty);
    end

    @(negedge clk);
    base_a = j.ba; base_b = j.bb; base_c = j.bc;
    type_in = j.ty; rc_in = j.rcv;
    arready = 1'b0; rvalid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_cleared_on_start", err, 0);
    chk("mat_a_on_start", mat, MatA);
    chk("type_latched", data_type, j.ty);
    chk("rc_latched", rc, j.rcv);
    base_a = $urandom; base_b = $urandom; base_c = $urandom;
    type_in = type_t'($urandom_range(0, 3));
    rc_in = rc_t'($urandom_range(0, 2));

    while (!finished && cyc < 4000) begin
      pend_before = pend;
      if (exp_v) begin
        chk("valid_beat", valid, 1);
        d = q_data.pop_front(); ei = q_idx.pop_front(); em = q_mat.pop_front();
        chk("data_in", data_in, d);
        chk("burst_num", burst_num, ei[4:0]);
        chk("mat_tag", mat, em);
        chk("data_type_tag", data_type, j.ty);
        chk("rc_tag", rc, j.rcv);
        fwd++;
      end else begin
        chk("valid_idle", valid, 0);
      end
      if (hold) begin
        chk("ar_hold_valid", arvalid, 1);
        chk("ar_hold_addr", araddr, h_addr);
        chk("ar_hold_len", arlen, h_len);
      end
      if (pend_before) chk("rready_in_burst", rready, 1);

      if (done) begin
        chk("err_at_done", err, j.exp_err);
        chk("busy_at_done", busy, 0);
        chk("ar_count", ar_seen, 3);
        chk("beats_forwarded", fwd, total);
        finished = 1;
      end else if (abort_b && ar_seen == 2 && pend_before && bidx >= 3) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_arvalid", arvalid, 0);
        chk("abort_valid", valid, 0);
        chk("abort_rready", rready, 0);
        chk("abort_done", done, 0);
        chk("abort_mat", mat, MatA);
        rvalid = 1'b0; arready = 1'b0; start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end else begin
        arready = j.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        if (arvalid) chk("no_ar_overlap", pend_before, 0);
        hold = 0;
        if (arvalid && arready) begin
          if (ar_seen < 3) begin
            chk("araddr", araddr, exp_addr[ar_seen]);
            chk("arlen", arlen, exp_len[ar_seen]);
          end
          chk("arsize", arsize, 3'b101);
          chk("arburst", arburst, 2'b01);
          chk("arid", arid, TB_ID);
          pm = (ar_seen < 3) ? ar_seen : 2;
          ar_seen++;
          pend = 1; rem = exp_len[pm] + 1; bidx = 0;
        end else if (arvalid) begin
          hold = 1; h_addr = araddr; h_len = arlen;
        end
        exp_v_nxt = 0;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        if (pend_before && rem > 0 && (!j.gaps || $urandom_range(0, 3) != 0)) begin
          rvalid = 1'b1;
          rdata = d;
          rresp = (pm == j.resp_mat && bidx == j.resp_beat) ? 2'b10 : 2'b00;
          rlast = (bidx == exp_len[pm]);
          if (pm == j.last_mat && bidx == j.last_beat) rlast = !rlast;
          q_data.push_back(d); q_idx.push_back(bidx); q_mat.push_back(pm);
          bidx++; rem--;
          if (rem == 0) pend = 0;
          exp_v_nxt = 1;
        end else begin
          rvalid = 1'b0;
          rdata = d;
          rresp = 2'b11;
          rlast = 1'($urandom_range(0, 1));
        end
        start = (cyc == 7);  // must be ignored while busy
        exp_v = exp_v_nxt;
        cyc++;
        @(negedge clk);
      end
    end

    rvalid = 1'b0;
    if (!finished) begin
      checks++; errors++;
      $display("FAIL job_timeout: got no done after %0d cycles, expected done", cyc);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    start = 1'b1;  // lands in the DONE cycle, must be ignored
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    chk("no_ar_after_done", arvalid, 0);
    chk("valid_after_done", valid, 0);
  endtask

  job_t tbl [8];
  job_t r;
  int   m;

  initial begin
    tbl[0] = '{32'h1000, 32'h2000, 32'h3000, TypeFp32, RcM32N8, 1'b0, -1, 0, -1, 0, 1'b0};
    tbl[1] = '{32'h0004_0000, 32'h0004_0400, 32'h0008_0020, TypeInt8, RcM16N16, 1'b1,
               -1, 0, -1, 0, 1'b0};
    tbl[2] = '{32'h101F, 32'h2045, 32'h30FF, TypeFp16, RcM8N32, 1'b0, -1, 0, -1, 0, 1'b0};
    tbl[3] = '{32'h5000, 32'h6000, 32'h7000, TypeInt8, RcM32N8, 1'b1, 0, 3, -1, 0, 1'b1};
    tbl[4] = '{32'h8000, 32'h9000, 32'hA000, TypeFp16, RcM16N16, 1'b1, -1, 0, -1, 0, 1'b0};
    tbl[5] = '{32'h1000, 32'h2000, 32'h3000, TypeFp32, RcM32N8, 1'b1, -1, 0, 0, 5, 1'b1};
    tbl[6] = '{32'hB000, 32'hC000, 32'hD000, TypeBf16, RcM8N32, 1'b0, -1, 0, 2, 31, 1'b1};
    tbl[7] = '{32'hE000, 32'hF000, 32'h1_0000, TypeInt8, RcM32N8, 1'b1, -1, 0, 1, 0, 1'b1};

    rst_n = 1'b0; start = 1'b0;
    base_a = '0; base_b = '0; base_c = '0;
    type_in = TypeInt8; rc_in = RcM32N8;
    arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_rready", rready, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_burst_num", burst_num, 0);
    chk("rst_tags", {data_type, mat, rc}, 0);
    chk("rst_arsize", arsize, 3'b101);
    chk("rst_arburst", arburst, 2'b01);
    chk("rst_arid", arid, TB_ID);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_arvalid", arvalid, 0);

    for (int i = 0; i < 8; i++) run_job(tbl[i], 1'b0);

    for (int n = 0; n < 6; n++) begin
      r.ba = $urandom; r.bb = $urandom; r.bc = $urandom;
      r.ty = type_t'($urandom_range(0, 3));
      r.rcv = rc_t'($urandom_range(0, 2));
      r.gaps = 1'b1;
      m = int'($urandom_range(0, 5));
      r.resp_mat = (m > 2) ? -1 : m;
      r.resp_beat = (m > 2) ? 0 : int'($urandom_range(0, beats_ref(m, r.ty) - 1));
      m = int'($urandom_range(0, 5));
      r.last_mat = (m > 2) ? -1 : m;
      r.last_beat = (m > 2) ? 0 : int'($urandom_range(0, beats_ref(m, r.ty) - 1));
      r.exp_err = (r.resp_mat >= 0) || (r.last_mat >= 0);
      run_job(r, 1'b0);
    end

    run_job(tbl[1], 1'b1);
    run_job(tbl[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected summary");
    $fatal(1, "watchdog expired");
  end

endmodule
